// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the alignment rule used by the optional misalignment check.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_e;

  // Halves need an even address, words (and the reserved size) a word address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and replication, load shift and extend.
// Size 2'b11 falls through to word handling.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic [1:0]      addr_lo_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [15:0] sh;

  // Lane selection by access size and the low address bits.
  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    sh      = '0;
    case (size_i)
      SZ_B: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        sh      = 16'(rdata_i >> {addr_lo_i, 3'b000});
        rdata_o = {{24{~unsigned_i & sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        sh      = 16'(rdata_i >> {addr_lo_i[1], 4'b0000});
        rdata_o = {{16{~unsigned_i & sh[15]}}, sh};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute, memory and writeback.
// Optional: define LSU_MISALIGN_CHECK_EN to add misalign_err and reject
// misaligned halves/words without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  input  logic                req_wen,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [4:0]          req_rd,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [DATA_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [DATA_LEN-1:0] mem_rdata,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic                wb_dest_wen,
  output logic [4:0]          wb_rd,
  output logic [DATA_LEN-1:0] wb_data
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic                misalign_err
`endif
);

  lsu_state_e          state_q, state_d;
  logic [DATA_LEN-1:0] addr_q;
  logic                wen_q;
  logic [1:0]          size_q;
  logic                unsigned_q;
  logic [4:0]          rd_q;
  logic [DATA_LEN-1:0] mem_wdata_q;
  logic [3:0]          mem_wstrb_q;
  logic [DATA_LEN-1:0] wb_data_q;
  logic                dest_wen_q;
  logic                req_ready_q, mem_valid_q, wb_valid_q;
  logic                accept, capture, misalign;
  logic [1:0]          al_size, al_addr_lo;
  logic [3:0]          al_wstrb;
  logic [DATA_LEN-1:0] al_wdata, al_rdata;

  // The aligner sees the incoming request in IDLE and the latched one after.
  assign al_size    = (state_q == S_IDLE) ? req_size      : size_q;
  assign al_addr_lo = (state_q == S_IDLE) ? req_addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .size_i    (al_size),
    .addr_lo_i (al_addr_lo),
    .unsigned_i(unsigned_q),
    .wdata_i   (req_wdata),
    .rdata_i   (mem_rdata),
    .wstrb_o   (al_wstrb),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(req_size, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Next-state logic; rvalid only matters in WAIT_R.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        accept  = 1'b1;
        state_d = misalign ? S_RESP : S_REQ;
      end
      S_REQ:    if (mem_ready) state_d = wen_q ? S_RESP : S_WAIT_R;
      S_WAIT_R: if (mem_rvalid) begin
        capture = 1'b1;
        state_d = S_RESP;
      end
      S_RESP:   if (wb_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, handshake flags and latched transaction fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      rd_q        <= 5'd0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
      wb_data_q   <= '0;
      dest_wen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == S_IDLE);
      mem_valid_q <= (state_d == S_REQ);
      wb_valid_q  <= (state_d == S_RESP);
      if (accept) begin
        addr_q      <= req_addr;
        wen_q       <= req_wen;
        size_q      <= req_size;
        unsigned_q  <= req_unsigned;
        rd_q        <= req_rd;
        mem_wdata_q <= req_wen ? al_wdata : '0;
        mem_wstrb_q <= req_wen ? al_wstrb : 4'b0000;
        wb_data_q   <= '0;
        dest_wen_q  <= ~req_wen & ~misalign;
      end
      if (capture) wb_data_q <= al_rdata;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;

  // Error flag lives for exactly the RESP of a rejected access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   err_q <= 1'b0;
    else if (accept)           err_q <= misalign;
    else if (state_d == S_IDLE) err_q <= 1'b0;
  end

  assign misalign_err = err_q;
`endif

  assign req_ready   = req_ready_q;
  assign mem_valid   = mem_valid_q;
  assign mem_addr    = {addr_q[DATA_LEN-1:2], 2'b00};
  assign mem_wen     = wen_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign wb_valid    = wb_valid_q;
  assign wb_dest_wen = dest_wen_q;
  assign wb_rd       = rd_q;
  assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors, back-pressure,
// mid-transaction reset and randomized traffic against a behavioural model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_ready, wb_dest_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_obs;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        misalign_err;
  assign err_obs = misalign_err;
`else
  assign err_obs = 1'b0;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wen(req_wen), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest_wen(wb_dest_wen),
    .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef LSU_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  // ---------------- reference model ----------------
  function automatic int eff_size(input logic [1:0] size);
    return (size == 2'd3) ? 2 : int'(size);
  endfunction

  function automatic logic m_misaligned(input logic [31:0] addr, input logic [1:0] size);
`ifdef LSU_MISALIGN_CHECK_EN
    int a = int'(addr % 4);
    if (eff_size(size) == 1) return (a % 2) != 0;
    if (eff_size(size) == 2) return a != 0;
    return 1'b0;
`else
    return (addr === 32'hx) && (size === 2'bx);
`endif
  endfunction

  function automatic logic [3:0] m_strb(input logic [31:0] addr, input logic [1:0] size, input logic wen);
    int a = int'(addr % 4);
    if (!wen) return 4'b0000;
    case (eff_size(size))
      0:       return 4'(1 << a);
      1:       return 4'(3 << (2 * (a / 2)));
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wdata, input logic [1:0] size, input logic wen);
    if (!wen) return 32'd0;
    case (eff_size(size))
      0:       return (wdata % 256) * 32'h0101_0101;
      1:       return (wdata % 65536) * 32'h0001_0001;
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [31:0] rdata,
                                         input logic [1:0] size, input logic uns);
    int a = int'(addr % 4);
    logic [31:0] v;
    case (eff_size(size))
      0: begin
        v = (rdata / (32'd1 << (8 * a))) % 256;
        if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end
      1: begin
        v = (rdata / (32'd1 << (16 * (a / 2)))) % 65536;
        if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_addr = 0; req_wdata = 0; req_wen = 0; req_size = 0;
    req_unsigned = 0; req_rd = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    wb_ready = 0;
    repeat (2) @(negedge clk);
    n_tot++;
    if ({req_ready, mem_valid, wb_valid, wb_dest_wen, wb_rd, wb_data, mem_addr, mem_wstrb, mem_wdata, err_obs}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0}) begin
      $display("FAIL reset_state: rdy=%b mv=%b wv=%b dw=%b rd=%0d wbd=%h ma=%h st=%b`md=%h",
               req_ready, mem_valid, wb_valid, wb_dest_wen, wb_rd, wb_data, mem_addr, mem_wstrb, mem_wdata);
    end else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_tot++;
    if ({req_ready, mem_valid, wb_valid} !== 3'b100) begin
      $display("FAIL reset_release: rdy/mv/wv=%b%b%b want 100", req_ready, mem_valid, wb_valid);
    end else n_pass++;
  endtask

  // One full transaction with memory and writeback stalls of md / wd cycles.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic wen,
                        input logic [1:0] size, input logic uns, input logic [4:0] rd,
                        input logic [31:0] rdata, input int md, input int wd, input logic junk_rv,
                        input logic [31:0] e_addr, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                        input logic [31:0] e_wb, input logic e_dest, input logic e_mis, input string tag);
    int cyc, n;
    logic saw_mv;
    n_tot++;
    if (req_ready !== 1'b1) $display("FAIL %s_ready: req_ready=%b want 1", tag, req_ready);
    else n_pass++;
    req_valid = 1; req_addr = addr; req_wdata = wdata; req_wen = wen;
    req_size = size; req_unsigned = uns; req_rd = rd;
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    cyc = 1;
    if (!e_mis) begin
      n = 0;
      while (mem_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; cyc++; end
      for (int i = 0; i <= md; i++) begin
        n_tot++;
        if ({mem_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata, req_ready, wb_valid}
            !== {1'b1, e_addr, wen, e_strb, e_wdata, 1'b0, 1'b0})
          $display("FAIL %s_mem: mv=%b addr=%h wen=%b strb=%b wd=%h rdy=%b wv=%b want addr=%h strb=%b wd=%h",
                   tag, mem_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata, req_ready, wb_valid,
                   e_addr, e_strb, e_wdata);
        else n_pass++;
        if (i == md) begin mem_ready = 1; mem_rvalid = junk_rv; mem_rdata = ~rdata; end
        @(negedge clk); cyc++;
      end
      mem_ready = 0; mem_rvalid = 0;
      if (!wen) begin
        mem_rvalid = 1; mem_rdata = rdata;
        @(negedge clk); cyc++;
        mem_rvalid = 0; mem_rdata = $urandom;
      end
    end
    saw_mv = 1'b0;
    n = 0;
    while (wb_valid !== 1'b1 && n < 20) begin
      saw_mv |= (mem_valid === 1'b1);
      @(negedge clk); n++; cyc++;
    end
    if (e_mis) begin
      n_tot++;
      if (saw_mv || mem_valid !== 1'b0) $display("FAIL %s_no_mem: mem_valid seen=%b want 0", tag, saw_mv | mem_valid);
      else n_pass++;
    end
    if (md == 0) begin
      n_tot++;
      if (cyc != (e_mis ? 1 : (wen ? 2 : 3)))
        $display("FAIL %s_latency: got %0d cycles want %0d", tag, cyc, e_mis ? 1 : (wen ? 2 : 3));
      else n_pass++;
    end
    for (int i = 0; i <= wd; i++) begin
      n_tot++;
      if ({wb_valid, wb_dest_wen, wb_rd, wb_data, req_ready, mem_valid, err_obs}
          !== {1'b1, e_dest, rd, e_wb, 1'b0, 1'b0, e_mis})
        $display("FAIL %s_wb: wv=%b dw=%b rd=%0d data=%h rdy=%b mv=%b err=%b want dw=%b rd=%0d data=%h err=%b",
                 tag, wb_valid, wb_dest_wen, wb_rd, wb_data, req_ready, mem_valid, err_obs,
                 e_dest, rd, e_wb, e_mis);
      else n_pass++;
      if (i == wd) wb_ready = 1;
      @(negedge clk);
    end
    wb_ready = 0;
    n_tot++;
    if ({wb_valid, req_ready, err_obs} !== 3'b010)
      $display("FAIL %s_done: wv=%b rdy=%b err=%b want 0 1 0", tag, wb_valid, req_ready, err_obs);
    else n_pass++;
  endtask

  task automatic test_directed();
    do_txn(32'h8000_0003, 32'h0000_00AB, 1'b1, 2'b00, 1'b0, 5'd7, 32'h0, 0, 0, 1'b0,
           32'h8000_0000, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0, 1'b0, "st_byte");
    do_txn(32'h8000_0002, 32'h0, 1'b0, 2'b01, 1'b0, 5'd13, 32'h8001_1234, 0, 0, 1'b0,
           32'h8000_0000, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b1, 1'b0, "ld_half_s");
    do_txn(32'h8000_0001, 32'h0, 1'b0, 2'b00, 1'b1, 5'd21, 32'h0000_F000, 0, 0, 1'b0,
           32'h8000_0000, 4'b0000, 32'h0, 32'h0000_00F0, 1'b1, 1'b0, "ld_byte_u");
    do_txn(32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 2'b11, 1'b0, 5'd3, 32'h0, 0, 0, 1'b0,
           32'h8000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, "st_rsvd_word");
    do_txn(32'h8000_0008, 32'h0, 1'b0, 2'b00, 1'b0, 5'd9, 32'h1234_5680, 0, 0, 1'b1,
           32'h8000_0008, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0, "ld_same_cycle_rv");
  endtask

  task automatic test_backpressure();
    do_txn(32'h8000_0010, 32'h0, 1'b0, 2'b10, 1'b0, 5'd30, 32'hCAFE_F00D, 5, 3, 1'b0,
           32'h8000_0010, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, "bp_load");
    do_txn(32'h8000_0016, 32'h0000_5A5A, 1'b1, 2'b01, 1'b0, 5'd1, 32'h0, 5, 3, 1'b0,
           32'h8000_0014, 4'b1100, 32'h5A5A_5A5A, 32'h0, 1'b0, 1'b0, "bp_store");
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_CHECK_EN
    do_txn(32'h8000_0002, 32'h0, 1'b0, 2'b10, 1'b0, 5'd5, 32'h0, 0, 0, 1'b0,
           32'h8000_0000, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, "mis_word");
`else
    do_txn(32'h8000_0003, 32'h0, 1'b0, 2'b01, 1'b1, 5'd5, 32'hBEEF_1234, 0, 0, 1'b0,
           32'h8000_0000, 4'b0000, 32'h0, 32'h0000_BEEF, 1'b1, 1'b0, "wrap_half");
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    logic saw_wv;
    req_valid = 1; req_addr = 32'h8000_0020; req_wen = 0; req_size = 2'b10; req_rd = 5'd17;
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (mem_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    n_tot++;
    if ({req_ready, mem_valid, wb_valid} !== 3'b000)
      $display("FAIL rstmid_wait_r: rdy/mv/wv=%b%b%b want 000", req_ready, mem_valid, wb_valid);
    else n_pass++;
    rst = 1;
    #1;
    n_tot++;
    if ({req_ready, mem_valid, wb_valid, wb_rd, wb_dest_wen} !== {3'b100, 5'd0, 1'b0})
      $display("FAIL rstmid_idle: rdy/mv/wv=%b%b%b rd=%0d dw=%b want 100 0 0",
               req_ready, mem_valid, wb_valid, wb_rd, wb_dest_wen);
    else n_pass++;
    @(negedge clk);
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_rvalid = 0;
    saw_wv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      saw_wv |= (wb_valid !== 1'b0);
      @(negedge clk);
    end
    n_tot++;
    if (saw_wv || req_ready !== 1'b1)
      $display("FAIL rstmid_no_wb: wb_valid seen=%b rdy=%b want 0 1", saw_wv, req_ready);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] addr, wdata, rdata;
    logic        wen, uns, mis, junk;
    logic [1:0]  size;
    logic [4:0]  rd;
    for (int k = 0; k < 40; k++) begin
      addr  = 32'h8000_0000 + ($urandom % 256);
      wdata = $urandom; rdata = $urandom;
      wen   = 1'($urandom); uns = 1'($urandom); size = 2'($urandom);
      rd    = 5'($urandom); junk = ($urandom % 4) == 0;
      mis   = m_misaligned(addr, size);
      do_txn(addr, wdata, wen, size, uns, rd, rdata, int'($urandom % 4), int'($urandom % 3), junk,
             (addr / 4) * 4, mis ? 4'b0 : m_strb(addr, size, wen), mis ? 32'h0 : m_wdata(wdata, size, wen),
             (wen || mis) ? 32'h0 : m_load(addr, rdata, size, uns), !wen && !mis, mis, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_LEN, default 32, SHALL set the data and address width; only 32 is supported.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 req_valid  in  1  SHALL mark a valid request from the execute stage.
REQ-005 req_ready  out  1  SHALL mark that the unit can accept a request.
REQ-006 req_addr  in  DATA_LEN  SHALL be the byte address, i.e. the execute-stage sum.
REQ-007 req_wdata  in  DATA_LEN  SHALL be the store data, right-aligned.
REQ-008 req_wen  in  1  SHALL select store (1) or load (0).
REQ-009 req_size  in  2  SHALL select the access size: 00 byte, 01 half, 10 word; 11 is reserved.
REQ-010 req_unsigned  in  1  SHALL select zero-extension (1) or sign-extension (0) on loads.
REQ-011 req_rd  in  5  SHALL be the destination register index.
REQ-012 mem_valid out 1 / mem_ready in 1 SHALL form the memory request handshake.
REQ-013 mem_addr out DATA_LEN / mem_wen out 1 / mem_wdata out DATA_LEN / mem_wstrb out 4 SHALL carry the memory request.
REQ-014 mem_rvalid in 1 / mem_rdata in DATA_LEN SHALL carry the read response.
REQ-015 wb_valid out 1 / wb_ready in 1 SHALL form the writeback handshake.
REQ-016 wb_dest_wen out 1 / wb_rd out 5 / wb_data out DATA_LEN SHALL carry the writeback result.

Function
REQ-017 The unit SHALL run an FSM with states IDLE, REQ, WAIT_R and RESP, and SHALL hold one transaction at a time.
REQ-018 IDLE: req_ready=1; on req_valid the unit SHALL latch all req_* fields and go to REQ.
REQ-019 REQ: mem_valid=1, with mem_* outputs stable until mem_ready; on mem_ready a store SHALL go to RESP and a load SHALL go to WAIT_R.
REQ-020 WAIT_R: the unit SHALL capture the aligned and extended mem_rdata on mem_rvalid and go to RESP; mem_rvalid outside WAIT_R SHALL be ignored.
REQ-021 RESP: wb_valid=1, with fields stable until wb_ready; on wb_ready the unit SHALL return to IDLE.
REQ-022 The unit SHALL drive wb_dest_wen=1 for loads and 0 for stores, and SHALL drive wb_data=0 for stores.
REQ-023 mem_addr SHALL equal {addr[31:2],2'b00}.
REQ-024 Store data SHALL be replicated across byte lanes: byte replicated 4x, half replicated 2x, word unchanged.
REQ-025 mem_wstrb SHALL be: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111; loads 0000.
REQ-026 Load extraction SHALL shift mem_rdata right by 8*addr[1:0] for bytes and 16*addr[1] for halves, then sign- or zero-extend according to req_unsigned.
REQ-027 Minimum latency SHALL be: store req accepted -> wb_valid in 2 cycles; load in 3 cycles.
REQ-028 req_size=11 SHALL be treated as word.
REQ-029 A same-cycle mem_ready and mem_rvalid while in REQ SHALL still pass through WAIT_R; the memory SHALL NOT assert rvalid before the cycle after ready.

Reset
REQ-030 Reset SHALL force IDLE, with req_ready=1 and mem_valid=0, wb_valid=0 and all latched fields 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction; no wb_valid SHALL follow.

Configuration
REQ-032 With LSU_MISALIGN_CHECK_EN defined, the unit SHALL add output misalign_err (1 bit); a half with addr[0]=1, or a word with addr[1:0]!=0, SHALL skip REQ, go directly to RESP with wb_dest_wen=0 and misalign_err=1 during RESP, and issue no memory request.
REQ-033 Without LSU_MISALIGN_CHECK_EN, the port SHALL be absent and misaligned accesses SHALL use the low address bits as in REQ-025/026, with wrap inside the word.

Structure
REQ-034 Package lsu_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W) and the FSM state enumeration.
REQ-035 Sub-module lsu_align (combinational: wstrb generation, store replication, load shift/extend) SHALL be instantiated once.

Verification
REQ-036 Store byte, addr 0x80000003, wdata 0x000000AB -> mem_addr 0x80000000, wstrb 1000, wdata 0xABABABAB, wb_dest_wen=0.
REQ-037 Load half signed, addr 0x80000002, rdata 0x8001_1234 -> wb_data 0xFFFF8001, wb_dest_wen=1, wb_rd echoed.
REQ-038 Load byte unsigned, addr 0x80000001, rdata 0x0000F000 -> wb_data 0x000000F0.
REQ-039 Back-pressure: mem_ready low 5 cycles and wb_ready low 3 cycles -> all outputs stable, req_ready=0 throughout, exactly one wb_valid handshake.
REQ-040 rst pulse while in WAIT_R -> IDLE next edge; a later mem_rvalid is ignored and no wb_valid follows.
REQ-041 With LSU_MISALIGN_CHECK_EN, load word at 0x80000002 -> mem_valid never asserted, misalign_err=1 with wb_valid.
